// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB), 2-5 cycles per instruction.
// Memory handshake holds mem_req until mem_ack; no other backpressure.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        sign,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        memwr,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [1:0]  regdst,
  output logic [1:0]  write_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  aluctr,
  output logic        alusrc,
  output logic [1:0]  extop,
  output logic        addi,
  output logic        bltzal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LW, I_SW,
    I_BEQ, I_JAL, I_LUI, I_ADDI, I_J, I_ADDIU, I_BLTZAL
  } op_t;

  typedef struct packed {
    logic [1:0] regdst;
    logic [1:0] write_sel;
    logic [1:0] aluctr;
    logic       alusrc;
    logic [1:0] extop;
    logic       addi;
    logic       bltzal;
  } ctl_t;

  state_t     state_q;
  state_t     state_d;
  op_t        op;
  ctl_t       ctl;
  ctl_t       fld;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign rt           = instr[20:16];
  assign funct        = instr[5:0];
  assign unused_instr = ^{instr[25:21], instr[15:6]};

  always_comb begin
    op = I_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: op = I_ADDU;
          6'b100011: op = I_SUBU;
          6'b101010: op = I_SLT;
          6'b001000: op = I_JR;
          default:   op = I_ILL;
        endcase
      end
      // REGIMM: only bltzal (rt=10000) is implemented
      6'b000001: op = (rt == 5'b10000) ? I_BLTZAL : I_ILL;
      6'b000010: op = I_J;
      6'b000011: op = I_JAL;
      6'b000100: op = I_BEQ;
      6'b001000: op = I_ADDI;
      6'b001001: op = I_ADDIU;
      6'b001101: op = I_ORI;
      6'b001111: op = I_LUI;
      6'b100011: op = I_LW;
      6'b101011: op = I_SW;
      default:   op = I_ILL;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (op)
      I_SUBU: ctl.aluctr = 2'b01;
      I_SLT: begin
        ctl.aluctr    = 2'b01;
        ctl.write_sel = 2'b11;
      end
      I_ORI: begin
        ctl.regdst = 2'b01;
        ctl.aluctr = 2'b10;
        ctl.alusrc = 1'b1;
      end
      I_LW: begin
        ctl.regdst    = 2'b01;
        ctl.write_sel = 2'b01;
        ctl.alusrc    = 1'b1;
        ctl.extop     = 2'b01;
      end
      I_SW: begin
        ctl.regdst = 2'b01;
        ctl.alusrc = 1'b1;
        ctl.extop  = 2'b01;
      end
      I_BEQ: begin
        ctl.regdst = 2'b01;
        ctl.aluctr = 2'b01;
        ctl.extop  = 2'b01;
      end
      I_JAL: begin
        ctl.regdst    = 2'b10;
        ctl.write_sel = 2'b10;
      end
      I_LUI: begin
        ctl.regdst = 2'b01;
        ctl.alusrc = 1'b1;
        ctl.extop  = 2'b10;
      end
      I_ADDI: begin
        ctl.regdst = 2'b01;
        ctl.alusrc = 1'b1;
        ctl.extop  = 2'b01;
        ctl.addi   = 1'b1;
      end
      I_ADDIU: begin
        ctl.regdst = 2'b01;
        ctl.alusrc = 1'b1;
        ctl.extop  = 2'b01;
      end
      I_BLTZAL: begin
        ctl.regdst    = 2'b10;
        ctl.write_sel = 2'b10;
        ctl.aluctr    = 2'b11;
        ctl.extop     = 2'b01;
        ctl.bltzal    = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fld     = '0;
    mem_req = 1'b0;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    memwr   = 1'b0;
    illegal = 1'b0;
    pc_sel  = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op == I_ILL) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          fld     = ctl;
          state_d = EXEC;
        end
      end
      EXEC: begin
        fld     = ctl;
        state_d = FETCH;
        case (op)
          I_LW, I_SW: state_d = MEM;
          I_ADDU, I_SUBU, I_SLT, I_ORI, I_LUI, I_ADDI, I_ADDIU: state_d = WB;
          I_J: begin
            pc_we  = 1'b1;
            pc_sel = 2'b10;
          end
          I_JAL: begin
            pc_we  = 1'b1;
            pc_sel = 2'b10;
            reg_we = 1'b1;
          end
          I_JR: begin
            pc_we  = 1'b1;
            pc_sel = 2'b11;
          end
          I_BEQ: begin
            pc_we  = zero;
            pc_sel = 2'b01;
          end
          // link is written unconditionally, the branch only when rs is negative
          I_BLTZAL: begin
            reg_we = 1'b1;
            pc_we  = sign;
            pc_sel = 2'b01;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        fld     = ctl;
        mem_req = 1'b1;
        memwr   = (op == I_SW);
        if (mem_ack) state_d = (op == I_LW) ? WB : FETCH;
      end
      WB: begin
        fld     = ctl;
        reg_we  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (!reset_n) begin
      fld     = '0;
      mem_req = 1'b0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      memwr   = 1'b0;
      illegal = 1'b0;
      pc_sel  = 2'b00;
    end
  end

  assign state = reset_n ? state_q : FETCH;
  assign {regdst, write_sel, aluctr, alusrc, extop, addi, bltzal} = fld;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the
// instruction rules, replayed as stimulus and compared against the DUT every cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b1;
  logic        reset_n;
  logic [31:0] instr;
  logic        zero, sign, mem_ack;
  logic        mem_req, pc_we, ir_we, reg_we, memwr, illegal;
  logic [2:0]  state;
  logic [1:0]  regdst, write_sel, pc_sel, aluctr, extop;
  logic        alusrc, addi, bltzal;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero), .sign(sign),
    .mem_ack(mem_ack), .mem_req(mem_req), .pc_we(pc_we), .ir_we(ir_we),
    .reg_we(reg_we), .memwr(memwr), .illegal(illegal), .state(state),
    .regdst(regdst), .write_sel(write_sel), .pc_sel(pc_sel), .aluctr(aluctr),
    .alusrc(alusrc), .extop(extop), .addi(addi), .bltzal(bltzal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, pc_we, ir_we, reg_we, memwr, illegal;
    logic [1:0] regdst, write_sel, pc_sel, aluctr;
    logic       alusrc;
    logic [1:0] extop;
    logic       addi, bltzal;
  } out_t;

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic        z;
    logic        s;
    logic [31:0] ins;
    out_t        o;
    string       tag;
  } rec_t;

  typedef enum int {K_ILL, K_ALU, K_LD, K_ST, K_BEQ, K_J, K_JAL, K_JR, K_BAL} kind_t;

  rec_t        plan[$];
  rec_t        cur;
  out_t        act;
  logic [31:0] st_hist;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // Static control fields and behaviour class of one instruction word.
  function automatic out_t fields_of(input logic [31:0] ins, output kind_t k);
    out_t       f;
    logic [5:0] opc;
    logic [5:0] fn;
    f   = '0;
    k   = K_ILL;
    opc = ins[31:26];
    fn  = ins[5:0];
    case (opc)
      6'h00: begin
        case (fn)
          6'h21: k = K_ALU;
          6'h23: begin k = K_ALU; f.aluctr = 2'b01; end
          6'h2A: begin k = K_ALU; f.aluctr = 2'b01; f.write_sel = 2'b11; end
          6'h08: k = K_JR;
          default: k = K_ILL;
        endcase
      end
      6'h01: if (ins[20:16] == 5'b10000) begin
        k = K_BAL; f.regdst = 2'b10; f.write_sel = 2'b10; f.aluctr = 2'b11;
        f.extop = 2'b01; f.bltzal = 1'b1;
      end
      6'h02: k = K_J;
      6'h03: begin k = K_JAL; f.regdst = 2'b10; f.write_sel = 2'b10; end
      6'h04: begin k = K_BEQ; f.regdst = 2'b01; f.aluctr = 2'b01; f.extop = 2'b01; end
      6'h08: begin k = K_ALU; f.regdst = 2'b01; f.alusrc = 1'b1; f.extop = 2'b01; f.addi = 1'b1; end
      6'h09: begin k = K_ALU; f.regdst = 2'b01; f.alusrc = 1'b1; f.extop = 2'b01; end
      6'h0D: begin k = K_ALU; f.regdst = 2'b01; f.aluctr = 2'b10; f.alusrc = 1'b1; end
      6'h0F: begin k = K_ALU; f.regdst = 2'b01; f.alusrc = 1'b1; f.extop = 2'b10; end
      6'h23: begin k = K_LD; f.regdst = 2'b01; f.write_sel = 2'b01; f.alusrc = 1'b1; f.extop = 2'b01; end
      6'h2B: begin k = K_ST; f.regdst = 2'b01; f.alusrc = 1'b1; f.extop = 2'b01; end
      default: k = K_ILL;
    endcase
    if (k == K_ILL) f = '0;
    return f;
  endfunction

  function automatic void push(input rec_t b, input out_t o, input logic ack);
    rec_t r;
    r     = b;
    r.o   = o;
    r.ack = ack;
    plan.push_back(r);
  endfunction

  function automatic void push_reset(input int n);
    rec_t b;
    b.rst_n = 1'b0; b.ack = 1'b1; b.z = 1'b1; b.s = 1'b1;
    b.ins = 32'hFFFF_FFFF; b.o = '0; b.tag = "reset";
    for (int i = 0; i < n; i++) plan.push_back(b);
  endfunction

  // Expected cycle-by-cycle trace of one instruction. noise raises mem_ack in
  // cycles with no request; abort_mem>0 asserts reset after that many MEM cycles.
  function automatic void build(input string tag, input logic [31:0] ins, input logic z,
                                input logic s, input int fwait, input int mwait,
                                input logic noise, input int abort_mem);
    kind_t k;
    out_t  f, o;
    rec_t  b;
    f = fields_of(ins, k);
    b.rst_n = 1'b1; b.ack = 1'b0; b.z = z; b.s = s; b.ins = ins; b.o = '0; b.tag = tag;
    for (int i = 0; i < fwait; i++) begin
      o = '0; o.mem_req = 1'b1; push(b, o, 1'b0);
    end
    o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; push(b, o, 1'b1);
    if (k == K_ILL) begin
      o = '0; o.st = 3'd1; o.illegal = 1'b1; push(b, o, noise);
      return;
    end
    o = f; o.st = 3'd1; push(b, o, noise);
    o = f; o.st = 3'd2;
    case (k)
      K_J:   begin o.pc_we = 1'b1; o.pc_sel = 2'b10; end
      K_JAL: begin o.pc_we = 1'b1; o.pc_sel = 2'b10; o.reg_we = 1'b1; end
      K_JR:  begin o.pc_we = 1'b1; o.pc_sel = 2'b11; end
      K_BEQ: begin o.pc_we = z; o.pc_sel = 2'b01; end
      K_BAL: begin o.pc_we = s; o.pc_sel = 2'b01; o.reg_we = 1'b1; end
      default: o.pc_sel = 2'b00;
    endcase
    push(b, o, noise);
    if (k == K_LD || k == K_ST) begin
      o = f; o.st = 3'd3; o.mem_req = 1'b1; o.memwr = (k == K_ST);
      for (int i = 0; i < mwait; i++) begin
        if (abort_mem > 0 && i == abort_mem) begin
          b.rst_n = 1'b0; o = '0; push(b, o, 1'b1);
          return;
        end
        push(b, o, 1'b0);
      end
      push(b, o, 1'b1);
    end
    if (k == K_ALU || k == K_LD) begin
      o = f; o.st = 3'd4; o.reg_we = 1'b1; push(b, o, noise);
    end
  endfunction

  task automatic pin(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Replays the plan: inputs set 1 unit after the rising edge, outputs checked on the falling edge.
  task automatic run_plan();
    while (plan.size() > 0) begin
      cur     = plan.pop_front();
      reset_n = cur.rst_n;
      mem_ack = cur.ack;
      zero    = cur.z;
      sign    = cur.s;
      instr   = cur.ins;
      @(negedge clk);
      act = {state, mem_req, pc_we, ir_we, reg_we, memwr, illegal,
             regdst, write_sel, pc_sel, aluctr, alusrc, extop, addi, bltzal};
      checks++;
      if (act !== cur.o) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h required=%h (state got %0d required %0d)",
                 cur.tag, cyc, act, cur.o, state, cur.o.st);
      end
      st_hist = {st_hist[27:0], 1'b0, state};
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; instr = '0; zero = 1'b0; sign = 1'b0; mem_ack = 1'b0;
    st_hist = 32'hF;
    #1;
    push_reset(2);
    run_plan();

    build("addu", 32'h0022_1821, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    pin("addu_len", plan.size(), 4);
    st_hist = 32'hF;
    run_plan();
    pin("addu_states", int'(st_hist), 32'hF0124);

    build("lw", 32'h8C25_0004, 1'b0, 1'b0, 2, 3, 1'b0, 0);
    pin("lw_len", plan.size(), 10);
    run_plan();
    build("lw_fast", 32'h8C25_0004, 1'b0, 1'b0, 0, 0, 1'b1, 0);
    pin("lw_fast_len", plan.size(), 5);
    run_plan();
    build("sw", 32'hAC25_0008, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    pin("sw_len", plan.size(), 4);
    run_plan();
    build("beq_z0", 32'h1022_0003, 1'b0, 1'b1, 0, 0, 1'b1, 0);
    pin("beq_len", plan.size(), 3);
    run_plan();

    build("illegal_fc", 32'hFC00_0000, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    pin("illegal_len", plan.size(), 2);
    st_hist = 32'hF;
    run_plan();
    pin("illegal_states", int'(st_hist), 32'hF01);

    build("beq_z1",    32'h1022_0003, 1'b1, 1'b0, 1, 0, 1'b0, 0);
    build("bltzal_s0", 32'h0430_0010, 1'b1, 1'b0, 0, 0, 1'b1, 0);
    build("bltzal_s1", 32'h0430_0010, 1'b0, 1'b1, 0, 0, 1'b0, 0);
    build("bltz_ill",  32'h0420_0010, 1'b0, 1'b1, 0, 0, 1'b1, 0);
    build("j",         32'h0800_0010, 1'b0, 1'b0, 0, 0, 1'b1, 0);
    build("jal",       32'h0C00_0010, 1'b0, 1'b0, 1, 0, 1'b0, 0);
    build("jr",        32'h03E0_0008, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    build("ori",       32'h3422_0055, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    build("lui",       32'h3C01_1234, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    build("addi",      32'h2022_0005, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    build("addiu",     32'h2422_0005, 1'b0, 1'b0, 0, 0, 1'b1, 0);
    build("subu",      32'h0022_1823, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    build("slt",       32'h0022_182A, 1'b0, 1'b1, 0, 0, 1'b0, 0);
    build("add_ill",   32'h0022_1820, 1'b1, 1'b1, 0, 0, 1'b1, 0);
    build("sw_wait",   32'hAC25_0008, 1'b0, 1'b0, 0, 2, 1'b1, 0);
    run_plan();

    build("sw_rst", 32'hAC25_0008, 1'b0, 1'b0, 0, 5, 1'b0, 2);
    pin("sw_rst_len", plan.size(), 6);
    build("post_rst_addu", 32'h0022_1821, 1'b0, 1'b0, 1, 0, 1'b0, 0);
    run_plan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge only.
REQ-002 SHALL have ports: reset_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-003 SHALL have ports: instr  in  32  IR contents, stable from DECODE to the end of the instruction; zero  in  1  ALU equal flag; sign  in  1  rs[31]; mem_ack  in  1  memory done.
REQ-004 SHALL have ports: mem_req  out  1; pc_we  out  1; ir_we  out  1; reg_we  out  1; memwr  out  1; illegal  out  1; state  out  3.
REQ-005 SHALL have ports: regdst  out  2 (00 rd, 01 rt, 10 $31); write_sel  out  2 (00 ALU, 01 mem, 10 PC+4, 11 slt); pc_sel  out  2 (00 PC+4, 01 branch, 10 jump, 11 rs).
REQ-006 SHALL have ports: aluctr  out  2 (00 add, 01 sub, 10 or, 11 sign test); alusrc  out  1; extop  out  2 (00 zero, 01 sign, 10 lui); addi  out  1; bltzal  out  1.

Function
REQ-007 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; state output equals the current encoding; codes 5-7 SHALL go to FETCH on the next edge with no strobes.
REQ-008 In FETCH, mem_req SHALL be 1 and held until mem_ack=1; mem_ack SHALL be ignored when mem_req=0.
REQ-009 In FETCH with mem_ack=1, ir_we=1 and pc_we=1 with pc_sel=00 in that cycle, and the next state SHALL be DECODE; without mem_ack, the FSM SHALL stay in FETCH.
REQ-010 DECODE SHALL always go to EXEC, except that an unsupported opcode/funct, or opcode 000001 with rt!=10000, SHALL pulse illegal=1 for one cycle and return to FETCH with no write.
REQ-011 Supported instructions: addu, subu, slt, jr, ori, lw, sw, beq, jal, lui, addi, j, addiu, bltzal.
REQ-012 Static fields per instruction SHALL be held in DECODE through completion, using the single-cycle encodings: R-type regdst=00; I-type regdst=01; jal/bltzal regdst=10; ori aluctr=10, extop=00; lw/sw/addi/addiu/beq/bltzal extop=01; lui extop=10; subu/slt/beq aluctr=01; bltzal aluctr=11; slt write_sel=11; lw write_sel=01; jal/bltzal write_sel=10; addi output=1 only for addi; bltzal output=1 only for bltzal.
REQ-013 EXEC next state: lw/sw go to MEM; addu/subu/slt/ori/lui/addi/addiu go to WB; beq/j/jr/jal/bltzal go to FETCH.
REQ-014 EXEC actions: j sets pc_we=1, pc_sel=10; jal sets pc_we=1, pc_sel=10, reg_we=1; jr sets pc_we=1, pc_sel=11; beq sets pc_we=zero, pc_sel=01; bltzal sets reg_we=1 always, pc_we=sign, pc_sel=01.
REQ-015 MEM SHALL assert mem_req=1 until mem_ack; sw SHALL drive memwr=1 in every MEM cycle; on mem_ack, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-016 WB SHALL assert reg_we=1 for exactly one cycle and then go to FETCH.
REQ-017 pc_we, ir_we, reg_we, memwr and illegal SHALL be 0 in every state/condition not listed above; at most one pc_we pulse SHALL occur per state visit.
REQ-018 Latency with mem_ack in the first request cycle SHALL be: R/I ALU 4 cycles; lw 5; sw 4; beq/j/jr/jal/bltzal 3; illegal 2.

Reset
REQ-019 reset_n=0 at an edge SHALL set state=FETCH in any state, including mid-MEM, abandoning the instruction.
REQ-020 While reset_n=0, mem_req, pc_we, ir_we, reg_we, memwr and illegal SHALL be forced to 0, and all other outputs SHALL be 0.
REQ-021 On the first cycle with reset_n=1, the FSM SHALL be in FETCH with mem_req=1.

Verification
REQ-022 instr=addu $3,$1,$2 with mem_ack high -> states 0,1,2,4,0; reg_we=1 only in WB with regdst=00 and aluctr=00.
REQ-023 lw with mem_ack low for 3 cycles in MEM -> MEM held 4 cycles with memwr=0, then WB with write_sel=01 and reg_we=1.
REQ-024 beq with zero=0 -> no pc_we in EXEC; with zero=1 -> pc_we=1 and pc_sel=01 in EXEC.
REQ-025 bltzal with sign=0 -> reg_we=1, regdst=10, pc_we=0; with sign=1 -> pc_we=1 as well.
REQ-026 instr=0xFC000000 -> illegal=1 in DECODE, next state FETCH, no strobes.
REQ-027 sw held in MEM with memwr=1 and reset_n driven 0 -> memwr=0 in that cycle, FETCH after the edge, mem_req=1 once reset_n=1.
